ctrl_sequencer: RTL and testbench

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

---
 rtl/ctrl_seq_pkg.sv | 47 ++++
 rtl/ctrl_sequencer_if.sv | 19 +
 rtl/cond_eval.sv | 39 +++
 rtl/ctrl_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_seq_pkg.sv
// Shared constants for the control sequencer: opcodes, ALU modes,
// jump condition codes and FSM state encoding.
package ctrl_seq_pkg;

  localparam logic [6:0] OP_MOV = 7'h01;
  localparam logic [6:0] OP_LDD = 7'h02;
  localparam logic [6:0] OP_LDO = 7'h03;
  localparam logic [6:0] OP_LDI = 7'h04;
  localparam logic [6:0] OP_STD = 7'h05;
  localparam logic [6:0] OP_STO = 7'h06;
  localparam logic [6:0] OP_ADD = 7'h07;
  localparam logic [6:0] OP_ADI = 7'h08;
  localparam logic [6:0] OP_ADC = 7'h09;
  localparam logic [6:0] OP_SUB = 7'h0A;
  localparam logic [6:0] OP_SUC = 7'h0B;
  localparam logic [6:0] OP_CMP = 7'h0C;
  localparam logic [6:0] OP_CMI = 7'h0D;
  localparam logic [6:0] OP_JMP = 7'h0E;
  localparam logic [6:0] OP_CLL = 7'h1F;
  localparam logic [6:0] OP_RET = 7'h20;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_ADC    = 4'b0001;
  localparam logic [3:0] ALU_SUB    = 4'b0010;
  localparam logic [3:0] ALU_SUC    = 4'b0011;
  localparam logic [3:0] ALU_PASS_L = 4'b1001;
  localparam logic [3:0] ALU_PASS_R = 4'b1010;

  localparam logic [3:0] JC_ALW = 4'd0;
  localparam logic [3:0] JC_C   = 4'd1;
  localparam logic [3:0] JC_EQ  = 4'd2;
  localparam logic [3:0] JC_LT  = 4'd3;
  localparam logic [3:0] JC_GT  = 4'd4;
  localparam logic [3:0] JC_LE  = 4'd5;
  localparam logic [3:0] JC_GE  = 4'd6;
  localparam logic [3:0] JC_NE  = 4'd7;
  localparam logic [3:0] JC_OV  = 4'd8;
  localparam logic [3:0] JC_NOV = 4'd9;

  typedef enum logic [1:0] {
    EXEC,
    MEM_WAIT,
    CALL_WAIT,
    RET_WAIT
  } state_t;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Memory bus between the control sequencer (master) and the memory
// / stack side (slave).
interface ctrl_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic mem_sp;
  logic mdata_sp;
  logic mem_ack;

  modport master (
    output mem_req, mem_we, mem_sp, mdata_sp,
    input  mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_sp, mdata_sp,
    output mem_ack
  );
endinterface

// File: rtl/cond_eval.sv
// Jump condition evaluation: ALU flags + 4-bit condition code -> taken.
// Codes 10..15 are treated as unconditional.
module cond_eval
  import ctrl_seq_pkg::*;
#(
  parameter int FLAG_W = 5
) (
  input  logic [FLAG_W-1:0] flags,
  input  logic [3:0]        code,
  output logic              taken
);

  logic eq, cy, lt, ov;
  logic unused_hi;

  assign eq = flags[0];
  assign cy = flags[1];
  assign lt = flags[2];
  assign ov = flags[3];
  assign unused_hi = ^flags[FLAG_W-1:4];

  always_comb begin
    taken = 1'b1;
    unique case (code)
      JC_ALW: taken = 1'b1;
      JC_C:   taken = cy;
      JC_EQ:  taken = eq;
      JC_LT:  taken = lt;
      JC_GT:  taken = ~(lt | eq);
      JC_LE:  taken = lt | eq;
      JC_GE:  taken = ~lt;
      JC_NE:  taken = ~eq;
      JC_OV:  taken = ov;
      JC_NOV: taken = ~ov;
      default: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Instruction control sequencer with memory wait / timeout handling.
// Define CTRL_SEQ_CALL_RET_EN to enable the cll/ret stack instructions.
module ctrl_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int REG_CNT     = 8,
  parameter int FLAG_W      = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [15:0]                instr,
  input  logic                       instr_valid,
  input  logic [FLAG_W-1:0]          flags,
  ctrl_sequencer_if.master           bus,
  output logic                       pc_inc,
  output logic                       pc_ie,
  output logic                       reg_in_mux_ctl,
  output logic                       alu_r_mux_ctl,
  output logic                       alu_cin,
  output logic [3:0]                 alu_mode,
  output logic [$clog2(REG_CNT)-1:0] reg_l_ctl,
  output logic [$clog2(REG_CNT)-1:0] reg_r_ctl,
  output logic [REG_CNT-1:0]         gp_reg_ie,
  output logic                       alu_flags_ie,
  output logic                       sp_inc,
  output logic                       sp_dec,
  output logic                       busy,
  output logic                       bus_err
);

  localparam int RW = $clog2(REG_CNT);
  localparam int CW = $clog2(MEM_TIMEOUT);

  logic [6:0]         op;
  logic [RW-1:0]      tg, fo, so;
  logic [REG_CNT-1:0] tg_oh;
  logic               taken;
  logic               is_load, is_store;
  logic [3:0]         m_mode;
  logic [RW-1:0]      m_l;
  logic               tmo;
  logic               mem_ctl;
`ifdef CTRL_SEQ_CALL_RET_EN
  logic               call_ctl;
  logic               ret_ctl;
`endif

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;

  assign op    = instr[6:0];
  assign tg    = instr[7 +: RW];
  assign fo    = instr[10 +: RW];
  assign so    = instr[13 +: RW];
  assign tg_oh = REG_CNT'(1) << tg;
  assign tmo   = (cnt_q == CW'(MEM_TIMEOUT - 1));

  assign is_load  = (op == OP_LDD) || (op == OP_LDO);
  assign is_store = (op == OP_STD) || (op == OP_STO);
  assign m_mode   = (op == OP_LDO || op == OP_STO) ? ALU_ADD : ALU_PASS_R;
  assign m_l      = (op == OP_LDO) ? fo : (op == OP_STO) ? so : '0;

  cond_eval #(.FLAG_W(FLAG_W)) u_cond (
    .flags (flags),
    .code  (instr[10:7]),
    .taken (taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EXEC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == EXEC || state_d == EXEC) cnt_q <= '0;
      else cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_inc         = 1'b0;
    pc_ie          = 1'b0;
    reg_in_mux_ctl = 1'b0;
    alu_r_mux_ctl  = 1'b0;
    alu_cin        = 1'b0;
    alu_mode       = '0;
    reg_l_ctl      = '0;
    reg_r_ctl      = '0;
    gp_reg_ie      = '0;
    alu_flags_ie   = 1'b0;
    sp_inc         = 1'b0;
    sp_dec         = 1'b0;
    busy           = 1'b0;
    bus_err        = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_sp     = 1'b0;
    bus.mdata_sp   = 1'b0;
    mem_ctl        = 1'b0;
`ifdef CTRL_SEQ_CALL_RET_EN
    call_ctl       = 1'b0;
    ret_ctl        = 1'b0;
`endif
    // Reset masks all outputs, independent of the instruction inputs.
    if (rst_n) begin
      busy = (state_q != EXEC);
      unique case (state_q)
        EXEC: if (instr_valid) begin
          pc_inc = 1'b1;
          unique case (op)
            OP_MOV: begin
              alu_mode  = ALU_PASS_L;
              reg_l_ctl = fo;
              gp_reg_ie = tg_oh;
            end
            OP_LDI: begin
              alu_mode      = ALU_PASS_R;
              alu_r_mux_ctl = 1'b1;
              gp_reg_ie     = tg_oh;
            end
            OP_ADD, OP_SUB: begin
              alu_mode     = (op == OP_ADD) ? ALU_ADD : ALU_SUB;
              reg_l_ctl    = fo;
              reg_r_ctl    = so;
              gp_reg_ie    = tg_oh;
              alu_flags_ie = 1'b1;
            end
            OP_ADC, OP_SUC: begin
              alu_mode     = (op == OP_ADC) ? ALU_ADC : ALU_SUC;
              alu_cin      = flags[1];
              reg_l_ctl    = fo;
              reg_r_ctl    = so;
              gp_reg_ie    = tg_oh;
              alu_flags_ie = 1'b1;
            end
            OP_ADI: begin
              alu_mode      = ALU_ADD;
              alu_r_mux_ctl = 1'b1;
              reg_l_ctl     = fo;
              gp_reg_ie     = tg_oh;
              alu_flags_ie  = 1'b1;
            end
            OP_CMP: begin
              alu_mode     = ALU_SUB;
              reg_l_ctl    = fo;
              reg_r_ctl    = so;
              alu_flags_ie = 1'b1;
            end
            OP_CMI: begin
              alu_mode      = ALU_SUB;
              alu_r_mux_ctl = 1'b1;
              reg_l_ctl     = fo;
              alu_flags_ie  = 1'b1;
            end
            OP_JMP: begin
              alu_mode      = ALU_PASS_R;
              alu_r_mux_ctl = 1'b1;
              pc_ie         = taken;
              pc_inc        = ~taken;
            end
            OP_LDD, OP_LDO, OP_STD, OP_STO: begin
              mem_ctl = 1'b1;
              pc_inc  = 1'b0;
              state_d = MEM_WAIT;
            end
`ifdef CTRL_SEQ_CALL_RET_EN
            OP_CLL: begin
              call_ctl = 1'b1;
              pc_inc   = 1'b0;
              state_d  = CALL_WAIT;
            end
            OP_RET: begin
              ret_ctl = 1'b1;
              pc_inc  = 1'b0;
              state_d = RET_WAIT;
            end
`endif
            default: ;
          endcase
        end
        MEM_WAIT: begin
          mem_ctl = 1'b1;
          if (bus.mem_ack) begin
            pc_inc  = 1'b1;
            state_d = EXEC;
            if (is_load) begin
              reg_in_mux_ctl = 1'b1;
              gp_reg_ie      = tg_oh;
            end
          end else if (tmo) begin
            bus_err = 1'b1;
            pc_inc  = 1'b1;
            state_d = EXEC;
          end
        end
`ifdef CTRL_SEQ_CALL_RET_EN
        CALL_WAIT: begin
          call_ctl      = 1'b1;
          alu_mode      = ALU_PASS_R;
          alu_r_mux_ctl = 1'b1;
          if (bus.mem_ack) begin
            pc_ie   = 1'b1;
            sp_dec  = 1'b1;
            state_d = EXEC;
          end else if (tmo) begin
            bus_err = 1'b1;
            pc_inc  = 1'b1;
            state_d = EXEC;
          end
        end
        RET_WAIT: begin
          ret_ctl = 1'b1;
          if (bus.mem_ack) begin
            pc_ie          = 1'b1;
            reg_in_mux_ctl = 1'b1;
            sp_inc         = 1'b1;
            state_d        = EXEC;
          end else if (tmo) begin
            bus_err = 1'b1;
            pc_inc  = 1'b1;
            state_d = EXEC;
          end
        end
`endif
        default: state_d = EXEC;
      endcase
      // Address/data controls stay stable for the whole access.
      if (mem_ctl) begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = is_store;
        alu_r_mux_ctl = 1'b1;
        alu_mode      = m_mode;
        reg_l_ctl     = m_l;
        if (is_store) reg_r_ctl = fo;
      end
`ifdef CTRL_SEQ_CALL_RET_EN
      if (call_ctl) begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_sp   = 1'b1;
        bus.mdata_sp = 1'b1;
      end
      if (ret_ctl) begin
        bus.mem_req = 1'b1;
        bus.mem_sp  = 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: stimulus queues expected per-cycle
// outputs, a negedge monitor pops and compares them.
module tb_ctrl_sequencer;

  typedef struct packed {
    logic       pc_inc;
    logic       pc_ie;
    logic       reg_in;
    logic       alu_r;
    logic       cin;
    logic [3:0] mode;
    logic [2:0] l;
    logic [2:0] r;
    logic [7:0] ie;
    logic       req;
    logic       we;
    logic       fie;
    logic       msp;
    logic       mdsp;
    logic       spi;
    logic       spd;
    logic       busy;
    logic       berr;
  } snap_t;

  typedef struct {
    string nm;
    snap_t v;
  } item_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic [4:0]  flags;
  logic        pc_inc, pc_ie, reg_in_mux_ctl, alu_r_mux_ctl, alu_cin;
  logic [3:0]  alu_mode;
  logic [2:0]  reg_l_ctl, reg_r_ctl;
  logic [7:0]  gp_reg_ie;
  logic        alu_flags_ie, sp_inc, sp_dec, busy, bus_err;

  int checks   = 0;
  int failures = 0;
  item_t q[$];
  snap_t act;
  snap_t e;

  ctrl_sequencer_if bus ();

  ctrl_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .flags          (flags),
    .bus            (bus),
    .pc_inc         (pc_inc),
    .pc_ie          (pc_ie),
    .reg_in_mux_ctl (reg_in_mux_ctl),
    .alu_r_mux_ctl  (alu_r_mux_ctl),
    .alu_cin        (alu_cin),
    .alu_mode       (alu_mode),
    .reg_l_ctl      (reg_l_ctl),
    .reg_r_ctl      (reg_r_ctl),
    .gp_reg_ie      (gp_reg_ie),
    .alu_flags_ie   (alu_flags_ie),
    .sp_inc         (sp_inc),
    .sp_dec         (sp_dec),
    .busy           (busy),
    .bus_err        (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    act        = '0;
    act.pc_inc = pc_inc;
    act.pc_ie  = pc_ie;
    act.reg_in = reg_in_mux_ctl;
    act.alu_r  = alu_r_mux_ctl;
    act.cin    = alu_cin;
    act.mode   = alu_mode;
    act.l      = reg_l_ctl;
    act.r      = reg_r_ctl;
    act.ie     = gp_reg_ie;
    act.req    = bus.mem_req;
    act.we     = bus.mem_we;
    act.fie    = alu_flags_ie;
    act.msp    = bus.mem_sp;
    act.mdsp   = bus.mdata_sp;
    act.spi    = sp_inc;
    act.spd    = sp_dec;
    act.busy   = busy;
    act.berr   = bus_err;
  end

  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t it;
      it = q.pop_front();
      checks++;
      if (act !== it.v) begin
        failures++;
        $display("FAIL %s: got %h expected %h", it.nm, act, it.v);
      end
    end
  end

  task automatic step(input logic r, input logic [15:0] i,
                      input logic v, input logic [4:0] f,
                      input logic a, input string nm,
                      input snap_t x);
    @(posedge clk);
    #1;
    rst_n       = r;
    instr       = i;
    instr_valid = v;
    flags       = f;
    bus.mem_ack = a;
    q.push_back('{nm, x});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    instr       = '0;
    instr_valid = 1'b0;
    flags       = '0;
    bus.mem_ack = 1'b0;

    e = '0;
    step(0, 16'h4587, 1, 0, 0, "reset_zero", e);
    step(1, 16'h0000, 0, 0, 0, "idle", e);

    // add r3,r1,r2
    e = '0; e.pc_inc = 1; e.l = 1; e.r = 2; e.ie = 8'h08; e.fie = 1;
    step(1, 16'h4587, 1, 0, 0, "add", e);
    // adc r0,r4,r5 with carry
    e = '0; e.pc_inc = 1; e.cin = 1; e.mode = 4'b0001;
    e.l = 4; e.r = 5; e.ie = 8'h01; e.fie = 1;
    step(1, 16'hB009, 1, 5'b00010, 0, "adc", e);
    // ldi r6
    e = '0; e.pc_inc = 1; e.alu_r = 1; e.mode = 4'b1010; e.ie = 8'h40;
    step(1, 16'h0304, 1, 0, 0, "ldi", e);
    e = '0; e.pc_inc = 1;
    step(1, 16'h0015, 1, 0, 0, "undef_nop", e);

    // jumps
    e = '0; e.alu_r = 1; e.mode = 4'b1010; e.pc_inc = 1;
    step(1, 16'h038E, 1, 5'b00001, 0, "jne_not", e);
    step(1, 16'h020E, 1, 5'b00100, 0, "jgt_not", e);
    e.pc_inc = 0; e.pc_ie = 1;
    step(1, 16'h038E, 1, 5'b00000, 0, "jne_taken", e);
    step(1, 16'h040E, 1, 5'b01000, 0, "jov_taken", e);
    step(1, 16'h060E, 1, 5'b00000, 0, "jc12_always", e);

    // ldd r5, ack on third wait cycle
    e = '0; e.req = 1; e.alu_r = 1; e.mode = 4'b1010;
    step(1, 16'h0282, 1, 0, 0, "ldd_req", e);
    e.busy = 1;
    repeat (2) step(1, 16'h0282, 1, 0, 0, "ldd_wait", e);
    e.reg_in = 1; e.ie = 8'h20; e.pc_inc = 1;
    step(1, 16'h0282, 1, 0, 1, "ldd_ack", e);
    e = '0;
    step(1, 16'h0000, 0, 0, 1, "ack_in_exec_idle", e);
    e = '0; e.pc_inc = 1; e.l = 1; e.r = 2; e.ie = 8'h08; e.fie = 1;
    step(1, 16'h4587, 1, 0, 1, "ack_in_exec_add", e);

    // sto, immediate ack
    e = '0; e.req = 1; e.we = 1; e.alu_r = 1; e.mode = 4'b0000;
    e.l = 4; e.r = 2;
    step(1, 16'h8806, 1, 0, 0, "sto_req", e);
    e.busy = 1; e.pc_inc = 1;
    step(1, 16'h8806, 1, 0, 1, "sto_ack", e);

    // std, no ack -> timeout on 16th wait cycle
    e = '0; e.req = 1; e.we = 1; e.alu_r = 1; e.mode = 4'b1010; e.r = 3;
    step(1, 16'h0C05, 1, 0, 0, "std_req", e);
    e.busy = 1;
    for (int k = 0; k < 15; k++) step(1, 16'h0C05, 1, 0, 0, "std_wait", e);
    e.berr = 1; e.pc_inc = 1;
    step(1, 16'h0C05, 1, 0, 0, "std_timeout", e);
    e = '0;
    step(1, 16'h0C05, 0, 0, 0, "std_busy_drop", e);

    // ldo r1,[r2+imm], ack coincides with timeout cycle
    e = '0; e.req = 1; e.alu_r = 1; e.mode = 4'b0000; e.l = 2;
    step(1, 16'h0883, 1, 0, 0, "ldo_req", e);
    e.busy = 1;
    for (int k = 0; k < 15; k++) step(1, 16'h0883, 1, 0, 0, "ldo_wait", e);
    e.reg_in = 1; e.ie = 8'h02; e.pc_inc = 1;
    step(1, 16'h0883, 1, 0, 1, "ldo_ack_prio", e);

    // reset during MEM_WAIT
    e = '0; e.req = 1; e.alu_r = 1; e.mode = 4'b1010;
    step(1, 16'h0282, 1, 0, 0, "ldd2_req", e);
    e.busy = 1;
    step(1, 16'h0282, 1, 0, 0, "ldd2_wait", e);
    e = '0;
    step(0, 16'h0282, 1, 0, 0, "rst_in_wait", e);
    step(0, 16'h0282, 1, 0, 1, "rst_ack", e);
    step(1, 16'h0282, 0, 0, 1, "post_rst_ack", e);
    e = '0; e.pc_inc = 1; e.l = 1; e.r = 2; e.ie = 8'h08; e.fie = 1;
    step(1, 16'h4587, 1, 0, 0, "post_rst_add", e);

`ifdef CTRL_SEQ_CALL_RET_EN
    e = '0; e.msp = 1; e.mdsp = 1; e.req = 1; e.we = 1;
    step(1, 16'h001F, 1, 0, 0, "cll_req", e);
    e.busy = 1; e.pc_ie = 1; e.alu_r = 1; e.mode = 4'b1010; e.spd = 1;
    step(1, 16'h001F, 1, 0, 1, "cll_ack", e);
    e = '0; e.msp = 1; e.req = 1;
    step(1, 16'h0020, 1, 0, 0, "ret_req", e);
    e.busy = 1; e.pc_ie = 1; e.reg_in = 1; e.spi = 1;
    step(1, 16'h0020, 1, 0, 1, "ret_ack", e);
`else
    e = '0; e.pc_inc = 1;
    step(1, 16'h001F, 1, 0, 0, "cll_nop", e);
    step(1, 16'h001F, 1, 0, 1, "cll_nop2", e);
    step(1, 16'h0020, 1, 0, 0, "ret_nop", e);
`endif
    e = '0;
    step(1, 16'h0000, 0, 0, 0, "final_idle", e);

    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
